// File: rtl/input_command_scheduler.sv
// Button trackers with DAS/ARR auto-repeat feeding a single priority
// command slot with a valid/ready handshake toward the game FSM.
module input_cmd_tracker #(
  parameter int DAS_DELAY  = 20000000,
  parameter int ARR_PERIOD = 5000000,
  parameter bit REPEAT_EN  = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic ev
);

  localparam int MAXV = (DAS_DELAY > ARR_PERIOD) ? DAS_DELAY : ARR_PERIOD;
  localparam int CW   = (MAXV < 2) ? 1 : $clog2(MAXV);
  localparam logic [CW-1:0] DAS_LAST = CW'(DAS_DELAY - 1);
  localparam logic [CW-1:0] ARR_LAST = CW'(ARR_PERIOD - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_DELAY,
    S_REPEAT,
    S_HOLD
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!btn) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          cnt_d   = '0;
          state_d = REPEAT_EN ? S_DELAY : S_HOLD;
        end
        S_DELAY: begin
          if (cnt_q == DAS_LAST) begin
            cnt_d   = '0;
            state_d = S_REPEAT;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        S_REPEAT: begin
          if (cnt_q == ARR_LAST) cnt_d = '0;
          else                   cnt_d = cnt_q + CW'(1);
        end
        S_HOLD: state_d = S_HOLD;
      endcase
    end
  end

  always_comb begin
    ev = 1'b0;
    if (btn) begin
      unique case (state_q)
        S_IDLE:   ev = 1'b1;
        S_DELAY:  ev = (cnt_q == DAS_LAST);
        S_REPEAT: ev = (cnt_q == ARR_LAST);
        S_HOLD:   ev = 1'b0;
      endcase
    end
  end

endmodule

module input_command_scheduler #(
  parameter int DAS_DELAY  = 20000000,
  parameter int ARR_PERIOD = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_left,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_rotate,
  input  logic       btn_drop,
  input  logic       flush,
  input  logic       cmd_ready,
  output logic       cmd_valid,
  output logic [2:0] cmd_code
);

  // bit order: 0 LEFT, 1 RIGHT, 2 DOWN, 3 ROTATE, 4 DROP
  logic [4:0] ev;
  logic [4:0] pend_q, pend_d;
  logic       valid_q, valid_d;
  logic [2:0] code_q, code_d;
  logic [4:0] grant;
  logic [2:0] code_sel;
  logic       load;

  input_cmd_tracker #(
    .DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .REPEAT_EN(1'b1)
  ) u_left (.clk(clk), .rst(rst), .btn(btn_left), .ev(ev[0]));

  input_cmd_tracker #(
    .DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .REPEAT_EN(1'b1)
  ) u_right (.clk(clk), .rst(rst), .btn(btn_right), .ev(ev[1]));

  input_cmd_tracker #(
    .DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .REPEAT_EN(1'b1)
  ) u_down (.clk(clk), .rst(rst), .btn(btn_down), .ev(ev[2]));

  input_cmd_tracker #(
    .DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .REPEAT_EN(1'b0)
  ) u_rotate (.clk(clk), .rst(rst), .btn(btn_rotate), .ev(ev[3]));

  input_cmd_tracker #(
    .DAS_DELAY(DAS_DELAY), .ARR_PERIOD(ARR_PERIOD), .REPEAT_EN(1'b0)
  ) u_drop (.clk(clk), .rst(rst), .btn(btn_drop), .ev(ev[4]));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pend_q  <= '0;
      valid_q <= 1'b0;
      code_q  <= '0;
    end else begin
      pend_q  <= pend_d;
      valid_q <= valid_d;
      code_q  <= code_d;
    end
  end

  always_comb begin
    grant    = '0;
    code_sel = '0;
    priority case (1'b1)
      pend_q[4]: begin grant = 5'b10000; code_sel = 3'd5; end
      pend_q[3]: begin grant = 5'b01000; code_sel = 3'd4; end
      pend_q[0]: begin grant = 5'b00001; code_sel = 3'd1; end
      pend_q[1]: begin grant = 5'b00010; code_sel = 3'd2; end
      pend_q[2]: begin grant = 5'b00100; code_sel = 3'd3; end
      default: ;
    endcase
  end

  // new events are OR-ed after the grant clear so a same-edge set wins
  always_comb begin
    load    = !valid_q || cmd_ready;
    pend_d  = pend_q;
    valid_d = valid_q;
    code_d  = code_q;
    if (flush) begin
      pend_d  = '0;
      valid_d = 1'b0;
      code_d  = '0;
    end else begin
      if (load) begin
        pend_d  = pend_q & ~grant;
        valid_d = |pend_q;
        code_d  = code_sel;
      end
      pend_d = pend_d | ev;
    end
  end

  assign cmd_valid = valid_q;
  assign cmd_code  = code_q;

endmodule

// File: doc/input_command_scheduler.md
INPUT_COMMAND_SCHEDULER -- requirements
Module: input_command_scheduler

Interface
REQ-001 Parameter DAS_DELAY, default 20000000, cycles from first press event to first auto-repeat event (valid range >= 1).
REQ-002 Parameter ARR_PERIOD, default 5000000, cycles between subsequent auto-repeat events (valid range >= 1).
REQ-003 Port clk  input  1  single system clock; all state changes on posedge clk.
REQ-004 Port rst  input  1  asynchronous, active-high reset.
REQ-005 Ports btn_left, btn_right, btn_down, btn_rotate, btn_drop  input  1 each  button levels, already synchronized to clk, 1 = held.
REQ-006 Port flush  input  1  synchronous clear of all pending and presented commands.
REQ-007 Port cmd_ready  input  1  game FSM accepts the presented command.
REQ-008 Port cmd_valid  output  1  a command is presented.
REQ-009 Port cmd_code  output  3  command: 1 LEFT, 2 RIGHT, 3 DOWN, 4 ROTATE, 5 DROP; 0 when cmd_valid = 0.

Function
REQ-010 Each button SHALL have its own tracker FSM with states IDLE, DELAY, REPEAT, plus a counter sized for max(DAS_DELAY, ARR_PERIOD).
REQ-011 IDLE with button = 1 SHALL produce one press event, clear the counter, and go to DELAY (LEFT/RIGHT/DOWN) or HOLD-equivalent REPEAT-disabled wait (ROTATE/DROP).
REQ-012 ROTATE and DROP SHALL never auto-repeat: exactly one event per press, no further events until released for at least one cycle.
REQ-013 DELAY SHALL increment the counter each cycle; when the counter equals DAS_DELAY-1 it SHALL produce an event, clear the counter, and go to REPEAT.
REQ-014 REPEAT SHALL produce an event and clear the counter each time the counter equals ARR_PERIOD-1.
REQ-015 Button = 0 in any state SHALL return the tracker to IDLE with counter 0 on the same edge, producing no event.
REQ-016 Each command SHALL have a pending bit, set by its tracker event on the edge the event occurs.
REQ-017 An event on an already-set pending bit SHALL be coalesced (no count, no error).
REQ-018 Output slot SHALL load when cmd_valid = 0 or (cmd_valid = 1 and cmd_ready = 1): it takes the highest-priority pending command, DROP > ROTATE > LEFT > RIGHT > DOWN, and clears that pending bit.
REQ-019 If no command is pending at load time, cmd_valid SHALL go 0 and cmd_code 0.
REQ-020 While cmd_valid = 1 and cmd_ready = 0, cmd_code SHALL remain stable and no pending bit SHALL be cleared.
REQ-021 Latency: a button rising, sampled at edge k with the output slot free, SHALL give cmd_valid = 1 after edge k+1.
REQ-022 Back-to-back: with cmd_ready held 1 and multiple commands pending, one command SHALL be issued per cycle in priority order.
REQ-023 A new event for a command on the same edge its pending bit is granted SHALL leave that pending bit set (set wins over clear).
REQ-024 flush = 1 SHALL on that edge clear all pending bits, cmd_valid and cmd_code, and discard events from that edge; trackers keep their state, so held buttons do not re-fire until their next repeat or re-press.
REQ-025 LEFT and RIGHT held together SHALL track and queue independently; the scheduler applies no cancellation.

Reset
REQ-026 rst = 1 SHALL immediately force all trackers to IDLE, counters to 0, pending bits to 0, cmd_valid = 0, cmd_code = 0.
REQ-027 After rst deasserts, a button already held SHALL be treated as a new press on the first clock edge.
REQ-028 Reset asserted mid-repeat or mid-handshake SHALL drop the presented command without any cmd_valid glitch.

Verification (DAS_DELAY=4, ARR_PERIOD=2)
REQ-029 btn_left held 12 cycles with cmd_ready=1 -> LEFT events at cycle offsets 0, 4, 6, 8, 10; cmd_valid with code 1 exactly one cycle after each.
REQ-030 btn_rotate held 20 cycles -> exactly one code 4 command; release 1 cycle then press again -> a second code 4.
REQ-031 btn_drop, btn_rotate, btn_down rise on the same edge with cmd_ready=1 -> codes 5, 4, 3 on three consecutive cycles.
REQ-032 btn_right press with cmd_ready=0 for 10 cycles -> cmd_valid=1, code 2 stable for all 10 cycles; repeat events coalesce; after ready, code 2 reissued once, then idle.
REQ-033 flush pulsed while DOWN is presented and LEFT is pending -> next cycle cmd_valid=0, pending empty; held LEFT next fires at its following repeat boundary.
REQ-034 rst asserted asynchronously mid-REPEAT -> outputs 0 before the next edge; btn still held at release -> code fires again after DAS timing from a fresh press.
